// File: rtl/delivery_map_checker.sv
// delivery_map_checker
//
// Consumer end of the scrolling delivery map. Looks at the map cell under the
// player every cycle and turns it into collision / pickup events. It also keeps
// the lives, the score and the invulnerability window, and decides game over.
//
// Ports
//   clock               system clock
//   reset               synchronous, active-low reset
//   start               one-cycle pulse; begins or restarts a game (IDLE/OVER only)
//   move_map            map shift pulse; marks a row boundary
//   map_obstacles_flat  16 rows x 4 lanes of obstacle bits, row r at [4r+3:4r]
//   map_objectives_flat 16 rows x 4 lanes of objective bits, same layout
//   player_lane         lane the player occupies, 0..3
//   collision           one-cycle pulse on a counted hit
//   objective_collected one-cycle pulse on a counted pickup
//   lives               remaining lives
//   score               collected objectives, saturating
//   invulnerable        high while immune after a hit
//   game_over           high once lives are exhausted
//   consumed_mask       lanes of the current player row already consumed

module delivery_map_checker #(
  parameter int unsigned PLAYER_ROW   = 0,
  parameter int unsigned START_LIVES  = 3,
  parameter int unsigned INVULN_MOVES = 2,
  parameter int unsigned SCORE_W      = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               move_map,
  input  logic [63:0]        map_obstacles_flat,
  input  logic [63:0]        map_objectives_flat,
  input  logic [1:0]         player_lane,
  output logic               collision,
  output logic               objective_collected,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic               invulnerable,
  output logic               game_over,
  output logic [3:0]         consumed_mask
);

  localparam logic [3:0] RowSel     = 4'(PLAYER_ROW);
  localparam logic [2:0] StartLives = 3'(START_LIVES);
  localparam logic [3:0] InvMoves   = 4'(INVULN_MOVES);

  typedef enum logic [1:0] {StIdle, StRun, StInvuln, StOver} state_e;

  state_e             state_q;
  logic               collision_q;
  logic               pickup_q;
  logic [2:0]         lives_q;
  logic [SCORE_W-1:0] score_q;
  logic               invuln_q;
  logic               game_over_q;
  logic [3:0]         consumed_q;
  logic [3:0]         counter_q;

  logic [5:0] cell_idx;
  logic       cell_obs;
  logic       cell_obj;
  logic       cell_fresh;
  logic [3:0] lane_bit;
  logic       hit;
  logic       pickup;

  always_comb begin
    cell_idx   = {RowSel, player_lane};
    cell_obs   = map_obstacles_flat[cell_idx];
    cell_obj   = map_objectives_flat[cell_idx];
    cell_fresh = ~consumed_q[player_lane];
    lane_bit   = 4'b0001 << player_lane;
    hit        = cell_obs & cell_fresh;
    pickup     = cell_obj & cell_fresh;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StIdle;
      collision_q <= 1'b0;
      pickup_q    <= 1'b0;
      lives_q     <= '0;
      score_q     <= '0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
      consumed_q  <= '0;
      counter_q   <= '0;
    end else begin
      collision_q <= 1'b0;
      pickup_q    <= 1'b0;

      unique case (state_q)
        StIdle, StOver: begin
          if (start) begin
            lives_q     <= StartLives;
            score_q     <= '0;
            consumed_q  <= '0;
            counter_q   <= '0;
            game_over_q <= 1'b0;
            state_q     <= StRun;
          end
        end

        StRun: begin
          // A hit takes priority and consumes the lane, so a shared objective is lost.
          if (hit) begin
            collision_q <= 1'b1;
            lives_q     <= lives_q - 3'd1;
            consumed_q  <= consumed_q | lane_bit;
            counter_q   <= InvMoves;
            if (lives_q == 3'd1) begin
              state_q     <= StOver;
              game_over_q <= 1'b1;
            end else begin
              state_q  <= StInvuln;
              invuln_q <= 1'b1;
            end
          end else if (pickup) begin
            pickup_q   <= 1'b1;
            consumed_q <= consumed_q | lane_bit;
            if (!(&score_q)) score_q <= score_q + SCORE_W'(1);
          end
        end

        StInvuln: begin
          // Obstacles are neither counted nor masked while immune.
          if (pickup) begin
            pickup_q   <= 1'b1;
            consumed_q <= consumed_q | lane_bit;
            if (!(&score_q)) score_q <= score_q + SCORE_W'(1);
          end
          if (move_map) begin
            counter_q <= counter_q - 4'd1;
            if (counter_q == 4'd1) begin
              state_q  <= StRun;
              invuln_q <= 1'b0;
            end
          end
        end

        default: state_q <= StIdle;
      endcase

      // A row boundary clears the mask, overriding any lane set this cycle.
      if (move_map) consumed_q <= '0;
    end
  end

  assign collision           = collision_q;
  assign objective_collected = pickup_q;
  assign lives               = lives_q;
  assign score               = score_q;
  assign invulnerable        = invuln_q;
  assign game_over           = game_over_q;
  assign consumed_mask       = consumed_q;

endmodule
